// File: rtl/reg_bus_csr_endpoint.sv
// CSR endpoint: config words, counter control, 64-bit saturating counters with LSB-latched MSB snapshot.
// Writes land at the wvalid edge; reads answer one cycle after arvalid; no backpressure on either path.
module reg_bus_csr_endpoint #(
    parameter int unsigned               N_CFG     = 4,
    parameter logic [N_CFG*32-1:0]       CFG_RESET = '0,
    parameter int unsigned               N_CTR     = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  reg_wvalid,
    input  logic [15:0]           reg_waddr,
    input  logic [31:0]           reg_wdata,
    input  logic                  reg_arvalid,
    input  logic [15:0]           reg_araddr,
    output logic                  reg_rvalid,
    output logic [31:0]           reg_rdata,
    output logic [N_CFG*32-1:0]   cfg,
    output logic                  ctr_en,
    input  logic [N_CTR-1:0]      event_inc
);

    logic [N_CFG*32-1:0]      cfg_q, cfg_d;
    logic                     ctr_en_q, ctr_en_d;
    logic                     sat_any_q, sat_any_d;
    logic [N_CTR-1:0][63:0]   cnt_q, cnt_d;
    logic [31:0]              snap_hi_q, snap_hi_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rvalid_q;
    logic                     clr;
    logic [7:0]               wa;
    logic [7:0]               ra;

    assign wa = reg_waddr[7:0];
    assign ra = reg_araddr[7:0];

    always_comb begin
        cfg_d     = cfg_q;
        ctr_en_d  = ctr_en_q;
        clr       = 1'b0;
        cnt_d     = cnt_q;
        sat_any_d = sat_any_q;
        if (reg_wvalid) begin
            if (wa[7:6] == 2'b00) begin
                for (int i = 0; i < int'(N_CFG); i++) begin
                    if (wa[5:2] == 4'(i)) cfg_d[32*i +: 32] = reg_wdata;
                end
            end
            if (wa[7:2] == 6'h10) begin
                ctr_en_d = reg_wdata[0];
                clr      = reg_wdata[1];
            end
        end
        // Counters use the enable already in effect; a new CTRL value applies next cycle.
        for (int i = 0; i < int'(N_CTR); i++) begin
            if (ctr_en_q && event_inc[i]) begin
                if (~&cnt_q[i]) cnt_d[i] = cnt_q[i] + 64'd1;
                if (&cnt_q[i][63:1]) sat_any_d = 1'b1;
            end
        end
        if (clr) begin
            cnt_d     = '0;
            sat_any_d = 1'b0;
        end
    end

    // Read mux samples pre-update state, so a colliding write or clear is not visible yet.
    always_comb begin
        rdata_d   = rdata_q;
        snap_hi_d = snap_hi_q;
        if (reg_arvalid) begin
            rdata_d = '0;
            if (ra[7:6] == 2'b00) begin
                for (int i = 0; i < int'(N_CFG); i++) begin
                    if (ra[5:2] == 4'(i)) rdata_d = cfg_q[32*i +: 32];
                end
            end else if (ra[7:2] == 6'h10) begin
                rdata_d = {31'b0, ctr_en_q};
            end else if (ra[7:2] == 6'h11) begin
                rdata_d = {16'(N_CTR), 8'(N_CFG), 7'b0, sat_any_q};
            end else if (ra[7]) begin
                for (int i = 0; i < int'(N_CTR); i++) begin
                    if (ra[6:3] == 4'(i)) begin
                        if (ra[2]) begin
                            rdata_d = snap_hi_q;
                        end else begin
                            rdata_d   = cnt_q[i][31:0];
                            snap_hi_d = cnt_q[i][63:32];
                        end
                    end
                end
            end
        end
        if (clr) snap_hi_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_q     <= CFG_RESET;
            ctr_en_q  <= 1'b0;
            sat_any_q <= 1'b0;
            cnt_q     <= '0;
            snap_hi_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            ctr_en_q  <= ctr_en_d;
            sat_any_q <= sat_any_d;
            cnt_q     <= cnt_d;
            snap_hi_q <= snap_hi_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= reg_arvalid;
        end
    end

    assign reg_rvalid = rvalid_q;
    assign reg_rdata  = rdata_q;
    assign cfg        = cfg_q;
    assign ctr_en     = ctr_en_q;

endmodule

// File: tb/tb_reg_bus_csr_endpoint.sv
// Randomized and directed bench for reg_bus_csr_endpoint against an address-map level reference model.
module tb_reg_bus_csr_endpoint;

    localparam int unsigned N_CFG = 4;
    localparam int unsigned N_CTR = 4;
    localparam logic [127:0] CFG_RST = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [63:0]  MAX64   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               reg_wvalid = 1'b0;
    logic [15:0]        reg_waddr = '0;
    logic [31:0]        reg_wdata = '0;
    logic               reg_arvalid = 1'b0;
    logic [15:0]        reg_araddr = '0;
    logic               reg_rvalid;
    logic [31:0]        reg_rdata;
    logic [127:0]       cfg;
    logic               ctr_en;
    logic [N_CTR-1:0]   event_inc = '0;

    reg_bus_csr_endpoint #(.N_CFG(N_CFG), .CFG_RESET(CFG_RST), .N_CTR(N_CTR)) dut (
        .clk(clk), .rstn(rstn),
        .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
        .cfg(cfg), .ctr_en(ctr_en), .event_inc(event_inc)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] cfg_m [N_CFG];
    logic [63:0] cnt_m [N_CTR];
    logic        en_m, sat_m, rvalid_m;
    logic [31:0] snap_m, rdata_m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] cfg_pk();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < int'(N_CFG); i++) r[32*i +: 32] = cfg_m[i];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        int b;
        int k;
        b = int'(a[7:0]);
        if (b < 64) return (b / 4 < int'(N_CFG)) ? cfg_m[b / 4] : 32'h0;
        if (b / 4 == 16) return {31'b0, en_m};
        if (b / 4 == 17) return {16'(N_CTR), 8'(N_CFG), 7'b0, sat_m};
        if (b >= 128) begin
            k = (b - 128) / 8;
            if (k < int'(N_CTR)) return (b % 8 >= 4) ? snap_m : cnt_m[k][31:0];
        end
        return 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(N_CFG); i++) cfg_m[i] = CFG_RST[32*i +: 32];
        for (int i = 0; i < int'(N_CTR); i++) cnt_m[i] = '0;
        en_m = 0; sat_m = 0; snap_m = 0; rdata_m = 0; rvalid_m = 0;
    endtask

    task automatic m_cycle(input logic wv, input logic [15:0] wa, input logic [31:0] wd,
                           input logic av, input logic [15:0] aa, input logic [N_CTR-1:0] inc);
        logic [31:0] snap_n;
        logic        clr, en_n;
        int          b;
        snap_n = snap_m;
        clr    = 0;
        en_n   = en_m;
        rvalid_m = av;
        if (av) begin
            rdata_m = m_read(aa);
            b = int'(aa[7:0]);
            if (b >= 128 && b % 8 < 4 && (b - 128) / 8 < int'(N_CTR)) snap_n = cnt_m[(b - 128) / 8][63:32];
        end
        if (wv) begin
            b = int'(wa[7:0]);
            if (b < 64 && b / 4 < int'(N_CFG)) cfg_m[b / 4] = wd;
            else if (b / 4 == 16) begin en_n = wd[0]; clr = wd[1]; end
        end
        for (int i = 0; i < int'(N_CTR); i++) begin
            if (en_m && inc[i]) begin
                if (cnt_m[i] != MAX64) cnt_m[i] = cnt_m[i] + 1;
                if (cnt_m[i] == MAX64) sat_m = 1;
            end
        end
        if (clr) begin
            for (int i = 0; i < int'(N_CTR); i++) cnt_m[i] = '0;
            sat_m  = 0;
            snap_n = 0;
        end
        snap_m = snap_n;
        en_m   = en_n;
    endtask

    task automatic step(input string tag, input logic wv, input logic [15:0] wa, input logic [31:0] wd,
                        input logic av, input logic [15:0] aa, input logic [N_CTR-1:0] inc);
        @(negedge clk);
        reg_wvalid = wv; reg_waddr = wa; reg_wdata = wd;
        reg_arvalid = av; reg_araddr = aa; event_inc = inc;
        m_cycle(wv, wa, wd, av, aa, inc);
        @(posedge clk);
        #1;
        chk({tag, ".rvalid"}, 128'(reg_rvalid), 128'(rvalid_m));
        chk({tag, ".rdata"}, 128'(reg_rdata), 128'(rdata_m));
        chk({tag, ".cfg"}, cfg, cfg_pk());
        chk({tag, ".ctr_en"}, 128'(ctr_en), 128'(en_m));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, '0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [7:0] b;
        case ($urandom % 5)
            0: b = {2'b00, 4'($urandom), 2'($urandom)};
            1: b = {6'h10, 2'($urandom)};
            2: b = {6'h11, 2'($urandom)};
            3: b = {1'b1, 4'($urandom % N_CTR), 1'($urandom), 2'($urandom)};
            default: b = 8'($urandom);
        endcase
        return {8'($urandom), b};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] wa, aa;
        logic [31:0] wd;
        logic        wv, av;

        // T1 reset
        m_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        rstn = 1;
        #1;
        chk("t1_cfg", cfg, CFG_RST);
        chk("t1_rvalid", 128'(reg_rvalid), 128'(0));
        chk("t1_rdata", 128'(reg_rdata), 128'(0));
        step("t1_status", 0, 0, 0, 1, 16'h0044, '0);
        chk("t1_status_val", 128'(reg_rdata), 128'h0004_0400);
        idle("t1_idle");

        // T2 config write then read
        step("t2_wr", 1, 16'h0008, 32'hCAFE_0001, 0, 0, '0);
        chk("t2_cfg2", 128'(cfg[95:64]), 128'hCAFE_0001);
        step("t2_rd", 0, 0, 0, 1, 16'h0008, '0);
        chk("t2_rd_val", 128'(reg_rdata), 128'hCAFE_0001);
        idle("t2_after");

        // T3 counters and snapshot
        step("t3_ctrl", 1, 16'h0040, 32'h3, 0, 0, '0);
        repeat (10) step("t3_inc", 0, 0, 0, 0, 0, 4'b0010);
        step("t3_lsb", 0, 0, 0, 1, 16'h0088, '0);
        chk("t3_lsb_val", 128'(reg_rdata), 128'd10);
        step("t3_msb", 0, 0, 0, 1, 16'h008C, '0);
        chk("t3_msb_val", 128'(reg_rdata), 128'd0);
        step("t3_lsb2", 0, 0, 0, 1, 16'h0088, 4'b0010);
        step("t3_hold", 0, 0, 0, 0, 0, 4'b0010);
        step("t3_msb2", 0, 0, 0, 1, 16'h008C, 4'b0010);
        step("t3_lsb3", 0, 0, 0, 1, 16'h0088, '0);
        chk("t3_lsb3_val", 128'(reg_rdata), 128'd13);

        // T4 saturation and clear
        step("t4_clr0", 1, 16'h0040, 32'h3, 0, 0, '0);
        force dut.cnt_q = 256'(64'hFFFF_FFFF_FFFF_FFFE);
        #1;
        release dut.cnt_q;
        cnt_m[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        repeat (3) step("t4_inc", 0, 0, 0, 0, 0, 4'b0001);
        step("t4_lsb", 0, 0, 0, 1, 16'h0080, '0);
        chk("t4_lsb_val", 128'(reg_rdata), 128'hFFFF_FFFF);
        step("t4_msb", 0, 0, 0, 1, 16'h0084, '0);
        chk("t4_msb_val", 128'(reg_rdata), 128'hFFFF_FFFF);
        step("t4_stat", 0, 0, 0, 1, 16'h0044, '0);
        chk("t4_sat", 128'(reg_rdata), 128'h0004_0401);
        step("t4_clr", 1, 16'h0040, 32'h3, 1, 16'h0080, 4'b0001);
        chk("t4_preclr", 128'(reg_rdata), 128'hFFFF_FFFF);
        step("t4_post", 0, 0, 0, 1, 16'h0080, '0);
        chk("t4_post_val", 128'(reg_rdata), 128'd0);
        step("t4_stat2", 0, 0, 0, 1, 16'h0044, '0);
        chk("t4_sat_clr", 128'(reg_rdata), 128'h0004_0400);
        step("t4_msb2", 0, 0, 0, 1, 16'h0084, '0);

        // T5 collision and burst
        step("t5_coll", 1, 16'h0000, 32'hDEAD_BEEF, 1, 16'h0000, '0);
        chk("t5_old", 128'(reg_rdata), 128'h1111_1111);
        for (int i = 0; i < 4; i++) step("t5_burst", 0, 0, 0, 1, 16'(4 * i), '0);
        idle("t5_end");

        // T6 unmapped read and reset during a pending read
        step("t6_unmap", 0, 0, 0, 1, 16'h003C, '0);
        chk("t6_unmap_val", 128'(reg_rdata), 128'd0);
        @(negedge clk);
        reg_arvalid = 1; reg_araddr = 16'h0004;
        #2 rstn = 0;
        m_reset();
        @(posedge clk);
        #1;
        chk("t6_rst_rvalid", 128'(reg_rvalid), 128'd0);
        chk("t6_rst_rdata", 128'(reg_rdata), 128'd0);
        reg_arvalid = 0;
        @(negedge clk);
        rstn = 1;
        repeat (3) idle("t6_post");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wv = ($urandom % 3 == 0);
            wa = rand_addr();
            wd = $urandom;
            if (wa[7:2] == 6'h10) wd[1] = ($urandom % 16 == 0);
            av = ($urandom % 2 == 0);
            aa = rand_addr();
            step("rnd", wv, wa, wd, av, aa, N_CTR'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
